ec_scalar_mult_ctrl: RTL
========================

Name: ec_scalar_mult_ctrl

Overview:
- Left-to-right double-and-add sequencer that computes R = k·P over the prime-field curve datapath.
- Sits directly upstream and downstream of point_add: it drives P/Q operands into point_add, starts it, waits for Done, and consumes Rx/Ry.
- Uses a sibling point_double unit through an identical handshake for the doubling steps.
- Handles point-at-infinity and P == ±Q corner cases itself; neither arithmetic unit supports them.

Parameters:
WIDTH, 256, bit width of coordinates and scalar

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
Start  in  1  one-cycle pulse; latches k, Px, Py when IDLE
k  in  WIDTH  scalar
Px  in  WIDTH  base point x
Py  in  WIDTH  base point y
Busy  out  1  high from accepted Start until Done
Done  out  1  one-cycle pulse, result valid
Rx  out  WIDTH  result x (held until next Start)
Ry  out  WIDTH  result y
R_inf  out  1  result is point at infinity
pa_Reset  out  1  point_add start/reset (active-high, one-cycle pulse)
pa_Px, pa_Py, pa_Qx, pa_Qy  out  WIDTH each  point_add operands
pa_Done  in  1  point_add completion
pa_Rx, pa_Ry  in  WIDTH each  point_add result
pd_Reset  out  1  point_double start (active-high, one-cycle pulse)
pd_Px, pd_Py  out  WIDTH each  point_double operand
pd_Done  in  1  point_double completion
pd_Rx, pd_Ry  in  WIDTH each  point_double result

Behaviour:
- Reset low at a rising edge: state IDLE; Busy=0, Done=0, pa_Reset=1, pd_Reset=1 (both units held in reset); Rx=Ry=0; R_inf=1.
- Reset mid-operation aborts immediately; no Done pulse is produced.
- Internal state: accumulator (Ax, Ay, A_inf), latched P, scalar shift register, bit counter (0..WIDTH-1).
- States: IDLE -> LOAD -> SCAN -> DBL_REQ -> DBL_WAIT -> ADD_CHK -> ADD_REQ -> ADD_WAIT -> NEXT -> DONE -> IDLE.
- IDLE: Start=1 latches inputs and sets A_inf=1. Start while Busy is ignored.
- LOAD: if k==0, go to DONE with R_inf=1. Otherwise go to SCAN.
- SCAN: shift out leading zeros, one bit per cycle. At the first 1 bit, set A=P, A_inf=0, then go to NEXT.
- NEXT: if no bits remain, go to DONE. Otherwise decrement the counter and go to DBL_REQ.
- DBL_REQ: if Ay==0, the double is infinity (set A_inf=1, skip to ADD_CHK). Otherwise present A on pd_P*, pulse pd_Reset for exactly one cycle, and go to DBL_WAIT.
- DBL_WAIT: on pd_Done=1, capture pd_R* into A.
- ADD_CHK: evaluate the current bit.
  - Bit 0: go to NEXT.
  - Bit 1 and A_inf: set A=P.
  - Bit 1 and Ax==Px with Ay==Py: use the DBL path on P.
  - Bit 1 and Ax==Px with Ay!=Py: set A_inf=1.
  - Otherwise: go to ADD_REQ.
- ADD_REQ: present A on pa_P* and P on pa_Q*, pulse pa_Reset for one cycle, go to ADD_WAIT.
- ADD_WAIT: on pa_Done, capture pa_R* into A.
- Unit handshake: after its start pulse, pa_Reset/pd_Reset stay low until the corresponding Done is seen, then return high in the next cycle. Operands are stable from the start pulse through Done.
- A Done from a unit not currently waited on is ignored.
- DONE: drive Rx/Ry/R_inf from A (zeros when infinity), pulse Done for 1 cycle, drop Busy in the same cycle, go to IDLE.
- Latency: 2 + (leading zeros) + Σ(unit latencies) + ~3 cycles per processed bit.

Optional Feature:
- Macro: ECSM_CONST_TIME_EN.
- Defined:
  - No leading-zero skip; A starts at infinity.
  - All WIDTH bits are processed.
  - For a 0 bit, ADD_REQ still runs with the same operands and the result is discarded. A dummy add is also issued whenever an infinity shortcut fires.
  - Cycle count depends only on unit latencies, not on k.
- Undefined: behaviour exactly as above.

Decomposition:
- Package ec_pkg: WIDTH default constant, ec_point_t struct {x, y, inf}, the state enum.
- Sub-module ec_point_eq (combinational x-equal / y-equal compare), instantiated once.

Test Plan:
- Stub models return after 5 cycles; the adder returns the true affine sum on curve y²=x³+7 mod 17.
- k=0, P=(1,5) -> Done after LOAD, R_inf=1, Rx=Ry=0, zero pa/pd pulses.
- k=1, P=(1,5) -> Rx=1, Ry=5, R_inf=0, zero unit pulses.
- k=2 -> exactly one pd_Reset pulse, no pa_Reset pulse, result equals the stub double of P.
- k=5 (101b) -> pulse order pd, pd, pa; result matches the software model.
- Reset driven low during ADD_WAIT -> pa_Reset=1, Busy=0, no Done; a fresh Start with k=3 completes correctly.
- Start asserted while Busy -> ignored; the result equals the first request's result.

Source files
------------

// File: rtl/ec_pkg.sv
// ec_pkg: shared coordinate width, affine point type and sequencer states for ec_scalar_mult_ctrl.
package ec_pkg;

    localparam int EC_WIDTH = 256;

    typedef struct packed {
        logic [EC_WIDTH-1:0] x;
        logic [EC_WIDTH-1:0] y;
        logic                inf;
    } ec_point_t;

    localparam ec_point_t EC_INF = '{x: '0, y: '0, inf: 1'b1};

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DBL_REQ,
        S_DBL_WAIT,
        S_ADD_CHK,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_NEXT,
        S_DONE
    } state_e;

    // Deferred outcome of a constant-time add slot: the unit always runs, this picks what A becomes.
    typedef enum logic [1:0] {
        ADD_USE,
        ADD_KEEP,
        ADD_SET_P,
        ADD_SET_INF
    } add_mode_e;

endpackage

// File: rtl/ec_point_eq.sv
// ec_point_eq: combinational coordinate compare between the accumulator and the base point.
module ec_point_eq #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] ax_i,
    input  logic [WIDTH-1:0] ay_i,
    input  logic [WIDTH-1:0] bx_i,
    input  logic [WIDTH-1:0] by_i,
    output logic             x_eq_o,
    output logic             y_eq_o
);

    assign x_eq_o = (ax_i == bx_i);
    assign y_eq_o = (ay_i == by_i);

endmodule

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: left-to-right double-and-add sequencer around point_double / point_add.
// Define ECSM_CONST_TIME_EN for the constant-time schedule (every bit processed, dummy unit ops).
module ec_scalar_mult_ctrl
    import ec_pkg::*;
#(
    parameter int WIDTH = EC_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] Px,
    input  logic [WIDTH-1:0] Py,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Rx,
    output logic [WIDTH-1:0] Ry,
    output logic             R_inf,
    output logic             pa_Reset,
    output logic [WIDTH-1:0] pa_Px,
    output logic [WIDTH-1:0] pa_Py,
    output logic [WIDTH-1:0] pa_Qx,
    output logic [WIDTH-1:0] pa_Qy,
    input  logic             pa_Done,
    input  logic [WIDTH-1:0] pa_Rx,
    input  logic [WIDTH-1:0] pa_Ry,
    output logic             pd_Reset,
    output logic [WIDTH-1:0] pd_Px,
    output logic [WIDTH-1:0] pd_Py,
    input  logic             pd_Done,
    input  logic [WIDTH-1:0] pd_Rx,
    input  logic [WIDTH-1:0] pd_Ry
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    ec_point_t        a_q, a_d, p_q, p_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbl_p_q, dbl_p_d;
    logic [WIDTH-1:0] rx_q, ry_q;
    logic             rinf_q;
    logic             x_eq, y_eq;
    logic             a_dbl_inf;
`ifdef ECSM_CONST_TIME_EN
    add_mode_e        mode_q, mode_d;
    logic             dbl_inf_q, dbl_inf_d;
`endif

    ec_point_eq #(.WIDTH(EC_WIDTH)) u_eq (
        .ax_i   (a_q.x),
        .ay_i   (a_q.y),
        .bx_i   (p_q.x),
        .by_i   (p_q.y),
        .x_eq_o (x_eq),
        .y_eq_o (y_eq)
    );

    // Doubling infinity or a point with y == 0 yields infinity; the unit cannot do either.
    assign a_dbl_inf = a_q.inf || (a_q.y == '0);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        dbl_p_d = dbl_p_q;
`ifdef ECSM_CONST_TIME_EN
        mode_d    = mode_q;
        dbl_inf_d = dbl_inf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    p_d     = '{x: EC_WIDTH'(Px), y: EC_WIDTH'(Py), inf: 1'b0};
                    a_d     = EC_INF;
                    k_d     = k;
                    cnt_d   = CW'(WIDTH - 1);
                    dbl_p_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef ECSM_CONST_TIME_EN
                state_d = S_ADD_CHK;
`else
                state_d = (k_q == '0) ? S_DONE : S_SCAN;
`endif
            end
            S_SCAN: begin
                if (k_q[WIDTH-1]) begin
                    a_d     = p_q;
                    state_d = S_NEXT;
                end else begin
                    k_d   = k_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_NEXT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    k_d     = k_q << 1;
                    dbl_p_d = 1'b0;
                    state_d = S_DBL_REQ;
                end
            end
            S_DBL_REQ: begin
`ifdef ECSM_CONST_TIME_EN
                dbl_inf_d = a_dbl_inf;
                state_d   = S_DBL_WAIT;
`else
                if (a_dbl_inf) begin
                    a_d     = EC_INF;
                    state_d = dbl_p_q ? S_NEXT : S_ADD_CHK;
                end else begin
                    state_d = S_DBL_WAIT;
                end
`endif
            end
            S_DBL_WAIT: begin
                if (pd_Done) begin
                    a_d = '{x: EC_WIDTH'(pd_Rx), y: EC_WIDTH'(pd_Ry), inf: 1'b0};
`ifdef ECSM_CONST_TIME_EN
                    if (dbl_inf_q) a_d = EC_INF;
`endif
                    state_d = dbl_p_q ? S_NEXT : S_ADD_CHK;
                end
            end
            S_ADD_CHK: begin
`ifdef ECSM_CONST_TIME_EN
                state_d = S_ADD_REQ;
                mode_d  = ADD_USE;
                if (!k_q[WIDTH-1])      mode_d = ADD_KEEP;
                else if (a_q.inf)       mode_d = ADD_SET_P;
                else if (x_eq && y_eq) begin
                    dbl_p_d = 1'b1;
                    state_d = S_DBL_REQ;
                end
                else if (x_eq)          mode_d = ADD_SET_INF;
`else
                if (!k_q[WIDTH-1]) begin
                    state_d = S_NEXT;
                end else if (a_q.inf) begin
                    a_d     = p_q;
                    state_d = S_NEXT;
                end else if (x_eq && y_eq) begin
                    dbl_p_d = 1'b1;
                    state_d = S_DBL_REQ;
                end else if (x_eq) begin
                    a_d     = EC_INF;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_ADD_REQ;
                end
`endif
            end
            S_ADD_REQ: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (pa_Done) begin
`ifdef ECSM_CONST_TIME_EN
                    case (mode_q)
                        ADD_USE:     a_d = '{x: EC_WIDTH'(pa_Rx), y: EC_WIDTH'(pa_Ry), inf: 1'b0};
                        ADD_SET_P:   a_d = p_q;
                        ADD_SET_INF: a_d = EC_INF;
                        default:     a_d = a_q;
                    endcase
`else
                    a_d = '{x: EC_WIDTH'(pa_Rx), y: EC_WIDTH'(pa_Ry), inf: 1'b0};
`endif
                    state_d = S_NEXT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            rinf_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == S_DONE) begin
                rx_q   <= a_d.inf ? '0 : a_d.x[WIDTH-1:0];
                ry_q   <= a_d.inf ? '0 : a_d.y[WIDTH-1:0];
                rinf_q <= a_d.inf;
            end
        end
    end

    // NOTE: datapath registers carry no reset; each is written after Start before it is read.
    always_ff @(posedge Clk) begin
        a_q     <= a_d;
        p_q     <= p_d;
        k_q     <= k_d;
        cnt_q   <= cnt_d;
        dbl_p_q <= dbl_p_d;
`ifdef ECSM_CONST_TIME_EN
        mode_q    <= mode_d;
        dbl_inf_q <= dbl_inf_d;
`endif
    end

    // Units sit in reset except while their result is awaited, so operands stay stable until Done.
    assign Busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done     = (state_q == S_DONE);
    assign pa_Reset = (state_q != S_ADD_WAIT);
    assign pd_Reset = (state_q != S_DBL_WAIT);
    assign Rx       = rx_q;
    assign Ry       = ry_q;
    assign R_inf    = rinf_q;
    assign pa_Px    = a_q.x[WIDTH-1:0];
    assign pa_Py    = a_q.y[WIDTH-1:0];
    assign pa_Qx    = p_q.x[WIDTH-1:0];
    assign pa_Qy    = p_q.y[WIDTH-1:0];
    assign pd_Px    = a_q.x[WIDTH-1:0];
    assign pd_Py    = a_q.y[WIDTH-1:0];

endmodule
